divider_arbiter: RTL and testbench
==================================

DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001 Parameter N, default 4: operand/result width in bits, matching the shared Divider.
REQ-002 Parameter M, default 2: number of requesters, M >= 2.
REQ-003 i_clock  input  1  single clock; all state updates on rising edge.
REQ-004 i_reset  input  1  asynchronous, active-low reset.
REQ-005 i_req  input  M  per-requester request level; bit k = requester k.
REQ-006 i_dividend  input  M*N  packed dividends; slice [k*N +: N] = requester k.
REQ-007 i_divisor  input  M*N  packed divisors, same packing.
REQ-008 o_grant  output  M  one-hot owner of the divider; all-zero when idle.
REQ-009 o_done  output  M  one-hot, one-cycle completion pulse to the owner.
REQ-010 o_quotient, o_remainder  output  N each  result bus, valid while o_done != 0, held until the next completion.
REQ-011 o_undefined  output  1  divide-by-zero flag, qualified like o_quotient.
REQ-012 o_div_start  output  1  one-cycle start pulse to the Divider.
REQ-013 o_div_dividend, o_div_divisor  output  N each  latched operands driven to the Divider.
REQ-014 i_div_finished, i_div_quotient, i_div_remainder, i_div_undefined  input  1/N/N/1  Divider results.

Function
REQ-015 FSM states: IDLE, START, WAIT, DONE.
REQ-016 IDLE: if any i_req bit is set, grant one requester by round-robin from pointer p, latch its operands, go to START; else stay.
REQ-017 Round-robin: search order p, p+1, ..., p+M-1 modulo M; the first set bit wins.
REQ-018 p resets to 0 and becomes winner+1 (mod M) when that winner's DONE cycle occurs.
REQ-019 START: o_div_start=1 for exactly one cycle, then go to WAIT.
REQ-020 WAIT: i_div_finished is ignored in the START cycle; the first i_div_finished=1 sampled in WAIT captures the quotient, remainder and undefined flag, and the FSM goes to DONE.
REQ-021 DONE: if i_req[owner] is still 1, o_done[owner]=1 for one cycle and the result registers update. If the owner dropped its request during the operation, the result is discarded, no o_done pulse is issued, and the result registers keep their old values. Both cases then clear o_grant and return to IDLE.
REQ-022 o_grant is asserted for the whole START..DONE span and deasserts the cycle after DONE.
REQ-023 Operands are latched at grant; later changes on i_dividend/i_divisor do not affect the operation in flight.
REQ-024 Minimum request-to-done latency is 3 cycles plus Divider latency; back-to-back grants are separated by one IDLE cycle.
REQ-025 A requester must hold i_req high until its o_done; deasserting earlier cancels the result per REQ-021.
REQ-026 New requests that arrive during START/WAIT/DONE are only arbitrated in IDLE.
REQ-027 A divisor of 0 is passed through; the Divider's undefined flag is reported on o_undefined.

Reset
REQ-028 Asserting i_reset (low) at any time, including mid-operation, forces: state IDLE, p=0, o_grant=0, o_done=0, o_div_start=0, and all result and operand registers = 0.
REQ-029 After reset release, the first grant can occur on the first rising edge with i_req != 0.
REQ-030 The Divider shares i_reset, so no stale i_div_finished is seen after reset.

Structure
REQ-031 FSM state encoding goes in the shared package, e.g. divider_arbiter_pkg; widths are derived from N and M only.
REQ-032 One natural sub-module: rr_priority_picker (M-bit request plus pointer in, one-hot grant out, purely combinational).
REQ-033 The Divider is instantiated by the parent, not inside this block.

Verification
REQ-034 N=4, M=2. Single request: req0=1, 13/4 -> one o_div_start, then o_done[0] with quotient=3, remainder=1, undefined=0.
REQ-035 Simultaneous req=2'b11 after reset (p=0) -> requester 0 served first, then requester 1; a new simultaneous request then serves 1 first (fairness).
REQ-036 Divide by zero: req1=1, 7/0 -> o_done[1] with o_undefined=1.
REQ-037 Requester 0 drops i_req during WAIT -> no o_done; o_quotient keeps its previous value; p advances to 1.
REQ-038 Reset asserted during WAIT -> all outputs 0 next cycle; re-request 9/2 completes with quotient=4, remainder=1.
REQ-039 Operand change after grant (15/3 changed to 1/1 during WAIT) -> result quotient=5, remainder=0.

Source files
------------

// File: rtl/divider_arbiter_pkg.sv
// Shared types for the divider arbiter: FSM encoding and width helpers.
package divider_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic int ptr_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after i_ptr wins.
module rr_priority_picker #(
    parameter int M  = 2,
    parameter int PW = 1
) (
    input  logic [M-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [M-1:0]  o_grant
);

    // Walk from farthest to nearest offset so the nearest set bit overwrites last
    always_comb begin
        o_grant = '0;
        for (int i = M - 1; i >= 0; i--) begin
            if (i_req[(int'(i_ptr) + i) % M]) begin
                o_grant = M'(1) << ((int'(i_ptr) + i) % M);
            end
        end
    end

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one multi-cycle Divider among M requesters.
module divider_arbiter
    import divider_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 2
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic [M-1:0]   i_req,
    input  logic [M*N-1:0] i_dividend,
    input  logic [M*N-1:0] i_divisor,
    output logic [M-1:0]   o_grant,
    output logic [M-1:0]   o_done,
    output logic [N-1:0]   o_quotient,
    output logic [N-1:0]   o_remainder,
    output logic           o_undefined,
    output logic           o_div_start,
    output logic [N-1:0]   o_div_dividend,
    output logic [N-1:0]   o_div_divisor,
    input  logic           i_div_finished,
    input  logic [N-1:0]   i_div_quotient,
    input  logic [N-1:0]   i_div_remainder,
    input  logic           i_div_undefined
);

    localparam int PW = ptr_w(M);

    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_ptr;
    logic [M-1:0]  r_grant;
    logic [N-1:0]  r_dvd;
    logic [N-1:0]  r_dvs;
    logic [N-1:0]  r_cap_q;
    logic [N-1:0]  r_cap_r;
    logic          r_cap_u;
    logic [N-1:0]  r_out_q;
    logic [N-1:0]  r_out_r;
    logic          r_out_u;
    logic [M-1:0]  w_pick;
    logic [M-1:0]  w_done;
    logic [N-1:0]  w_dvd;
    logic [N-1:0]  w_dvs;
    logic [PW-1:0] w_owner;
    logic [PW-1:0] w_ptr_next;

    rr_priority_picker #(.M(M), .PW(PW)) u_picker (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick)
    );

    always_comb begin
        w_dvd   = '0;
        w_dvs   = '0;
        w_owner = '0;
        for (int k = 0; k < M; k++) begin
            if (w_pick[k]) begin
                w_dvd = i_dividend[k*N +: N];
                w_dvs = i_divisor[k*N +: N];
            end
            if (r_grant[k]) begin
                w_owner = PW'(k);
            end
        end
        w_ptr_next = (w_owner == PW'(M - 1)) ? '0 : w_owner + PW'(1);
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (|i_req) w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT:  if (i_div_finished) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
        endcase
    end

    // A dropped request in DONE suppresses the pulse and the result update
    assign w_done = (r_state == S_DONE) ? (r_grant & i_req) : '0;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_ptr   <= '0;
            r_grant <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_cap_q <= '0;
            r_cap_r <= '0;
            r_cap_u <= 1'b0;
            r_out_q <= '0;
            r_out_r <= '0;
            r_out_u <= 1'b0;
        end else begin
            if (r_state == S_IDLE && |i_req) begin
                r_grant <= w_pick;
                r_dvd   <= w_dvd;
                r_dvs   <= w_dvs;
            end
            if (r_state == S_WAIT && i_div_finished) begin
                r_cap_q <= i_div_quotient;
                r_cap_r <= i_div_remainder;
                r_cap_u <= i_div_undefined;
            end
            if (r_state == S_DONE) begin
                r_grant <= '0;
                r_ptr   <= w_ptr_next;
                if (|w_done) begin
                    r_out_q <= r_cap_q;
                    r_out_r <= r_cap_r;
                    r_out_u <= r_cap_u;
                end
            end
        end
    end

    assign o_grant        = r_grant;
    assign o_done         = w_done;
    assign o_div_start    = (r_state == S_START);
    assign o_div_dividend = r_dvd;
    assign o_div_divisor  = r_dvs;
    assign o_quotient     = (|w_done) ? r_cap_q : r_out_q;
    assign o_remainder    = (|w_done) ? r_cap_r : r_out_r;
    assign o_undefined    = (|w_done) ? r_cap_u : r_out_u;

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter with a behavioural Divider and round-robin model.
module tb_divider_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic [1:0] grant;
    logic [1:0] done;
    logic [3:0] quo;
    logic [3:0] rem;
    logic       undef;
    logic       dstart;
    logic [3:0] d_dvd;
    logic [3:0] d_dvs;
    logic       fin;
    logic [3:0] dq;
    logic [3:0] dr;
    logic       du;

    int total = 0;
    int bad   = 0;
    int div_lat = 0;
    int exp_p = 0;
    logic [3:0] last_q = 0;
    logic [3:0] last_r = 0;
    logic       last_u = 0;

    divider_arbiter #(.N(4), .M(2)) dut (
        .i_clock         (clk),
        .i_reset         (rst_n),
        .i_req           (req),
        .i_dividend      (dvd),
        .i_divisor       (dvs),
        .o_grant         (grant),
        .o_done          (done),
        .o_quotient      (quo),
        .o_remainder     (rem),
        .o_undefined     (undef),
        .o_div_start     (dstart),
        .o_div_dividend  (d_dvd),
        .o_div_divisor   (d_dvs),
        .i_div_finished  (fin),
        .i_div_quotient  (dq),
        .i_div_remainder (dr),
        .i_div_undefined (du)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Divider stand-in: latency div_lat (or random 0..3 when negative)
    logic       busy;
    int         cnt;
    logic [3:0] da;
    logic [3:0] db;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 0; cnt <= 0; fin <= 0;
            da <= 0; db <= 0; dq <= 0; dr <= 0; du <= 0;
        end else begin
            fin <= 0;
            if (dstart) begin
                busy <= 1;
                da   <= d_dvd;
                db   <= d_dvs;
                cnt  <= (div_lat < 0) ? int'($urandom_range(3, 0)) : div_lat;
            end else if (busy) begin
                if (cnt == 0) begin
                    fin  <= 1;
                    busy <= 0;
                    dq   <= (db == 0) ? 4'hF : da / db;
                    dr   <= (db == 0) ? da : da % db;
                    du   <= (db == 0);
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    function automatic int rr_win(input int p, input logic [1:0] m);
        for (int i = 0; i < 2; i++) begin
            if (m[(p + i) % 2]) return (p + i) % 2;
        end
        return -1;
    endfunction

    task automatic wait_done(output int who, output logic [3:0] q,
                             output logic [3:0] r, output logic u,
                             output int starts, output int cyc,
                             output logic [1:0] g);
        who = -1; q = 0; r = 0; u = 0; starts = 0; cyc = 0; g = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            cyc++;
            if (dstart) begin
                starts++;
                g = grant;
            end
            if (done != 0) begin
                who = (done == 2'b01) ? 0 : (done == 2'b10) ? 1 : -2;
                q = quo; r = rem; u = undef;
                break;
            end
        end
    endtask

    task automatic do_reset();
        req = 0; dvd = 0; dvs = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        exp_p = 0; last_q = 0; last_r = 0; last_u = 0;
    endtask

    task automatic test_reset();
        req = 0; dvd = 0; dvs = 0;
        rst_n = 0;
        @(negedge clk);
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", grant); end
        total++; if (done !== 2'b00) begin bad++; $display("FAIL reset_done got=%b exp=00", done); end
        total++; if (dstart !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", dstart); end
        total++; if ({quo, rem, undef} !== 9'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", {quo, rem, undef}); end
        total++; if ({d_dvd, d_dvs} !== 8'h0) begin bad++; $display("FAIL reset_operands got=%h exp=0", {d_dvd, d_dvs}); end
        rst_n = 1;
        exp_p = 0; last_q = 0; last_r = 0; last_u = 0;
    endtask

    task automatic test_single();
        int who, st, cyc;
        logic [3:0] q, r;
        logic u;
        logic [1:0] g;
        div_lat = 0;
        @(posedge clk); #1;
        dvd = 8'h0D; dvs = 8'h04; req = 2'b01;
        wait_done(who, q, r, u, st, cyc, g);
        total++; if (who !== 0) begin bad++; $display("FAIL single_who got=%0d exp=0", who); end
        total++; if (st !== 1) begin bad++; $display("FAIL single_starts got=%0d exp=1", st); end
        total++; if (g !== 2'b01) begin bad++; $display("FAIL single_grant got=%b exp=01", g); end
        total++; if (cyc !== 5) begin bad++; $display("FAIL single_latency got=%0d exp=5", cyc); end
        total++; if ({q, r, u} !== {4'd3, 4'd1, 1'b0}) begin bad++; $display("FAIL single_result got=%h exp=%h", {q, r, u}, {4'd3, 4'd1, 1'b0}); end
        exp_p = 1; last_q = 3; last_r = 1; last_u = 0;
        @(posedge clk); #1;
        req = 0;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL single_release got=%b exp=00", grant); end
        @(negedge clk);
        total++; if ({quo, rem} !== {last_q, last_r}) begin bad++; $display("FAIL single_hold got=%h exp=%h", {quo, rem}, {last_q, last_r}); end
    endtask

    task automatic test_back_to_back();
        int who, st, cyc, w;
        logic [3:0] q, r;
        logic u;
        logic [1:0] g;
        do_reset();
        div_lat = 0;
        @(posedge clk); #1;
        dvd = {4'd14, 4'd8}; dvs = {4'd5, 4'd3}; req = 2'b11;
        for (int n = 0; n < 4; n++) begin
            w = rr_win(exp_p, req);
            wait_done(who, q, r, u, st, cyc, g);
            total++; if (who !== w) begin bad++; $display("FAIL fair_who[%0d] got=%0d exp=%0d", n, who, w); end
            total++; if (cyc !== 5) begin bad++; $display("FAIL fair_gap[%0d] got=%0d exp=5", n, cyc); end
            total++;
            if ({q, r} !== (w == 0 ? {4'd2, 4'd2} : {4'd2, 4'd4})) begin
                bad++; $display("FAIL fair_result[%0d] got=%h", n, {q, r});
            end
            exp_p = (w + 1) % 2;
            last_q = q; last_r = r; last_u = u;
        end
        @(posedge clk); #1;
        req = 0;
    endtask

    task automatic test_divzero();
        int who, st, cyc;
        logic [3:0] q, r;
        logic u;
        logic [1:0] g;
        div_lat = 1;
        @(posedge clk); #1;
        dvd = {4'd7, 4'd0}; dvs = {4'd0, 4'd0}; req = 2'b10;
        wait_done(who, q, r, u, st, cyc, g);
        total++; if (who !== 1) begin bad++; $display("FAIL dz_who got=%0d exp=1", who); end
        total++; if (u !== 1'b1) begin bad++; $display("FAIL dz_undefined got=%b exp=1", u); end
        exp_p = 0; last_q = 4'hF; last_r = 4'd7; last_u = 1;
        @(posedge clk); #1;
        req = 0;
    endtask

    task automatic test_cancel();
        int who, st, cyc, seen, dones;
        logic [3:0] q, r;
        logic u;
        logic [1:0] g;
        div_lat = 2;
        seen = 0; dones = 0;
        @(posedge clk); #1;
        dvd = {4'd6, 4'd5}; dvs = {4'd3, 4'd2}; req = 2'b01;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (dstart) seen = 1;
        end
        total++; if (seen !== 1) begin bad++; $display("FAIL cancel_start got=%0d exp=1", seen); end
        @(negedge clk);
        req = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done != 0) dones++;
        end
        exp_p = 1;
        total++; if (dones !== 0) begin bad++; $display("FAIL cancel_done got=%0d exp=0", dones); end
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL cancel_grant got=%b exp=00", grant); end
        total++;
        if ({quo, rem, undef} !== {last_q, last_r, last_u}) begin
            bad++; $display("FAIL cancel_hold got=%h exp=%h", {quo, rem, undef}, {last_q, last_r, last_u});
        end
        @(posedge clk); #1;
        req = 2'b11;
        wait_done(who, q, r, u, st, cyc, g);
        total++; if (who !== rr_win(exp_p, 2'b11)) begin bad++; $display("FAIL cancel_ptr got=%0d exp=1", who); end
        total++; if ({q, r} !== {4'd2, 4'd0}) begin bad++; $display("FAIL cancel_next got=%h exp=20", {q, r}); end
        exp_p = 0; last_q = q; last_r = r; last_u = u;
        @(posedge clk); #1;
        req = 0;
    endtask

    task automatic test_reset_mid();
        int who, st, cyc, seen;
        logic [3:0] q, r;
        logic u;
        logic [1:0] g;
        div_lat = 3;
        seen = 0;
        @(posedge clk); #1;
        dvd = {4'd11, 4'd9}; dvs = {4'd3, 4'd2}; req = 2'b01;
        wait_done(who, q, r, u, st, cyc, g);
        total++; if (who !== 0) begin bad++; $display("FAIL rmid_pre got=%0d exp=0", who); end
        @(posedge clk); #1;
        req = 2'b10;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (dstart) seen = 1;
        end
        @(negedge clk);
        rst_n = 0;
        #1;
        total++;
        if ({grant, done, dstart, quo, rem, undef, d_dvd, d_dvs} !== 22'h0) begin
            bad++; $display("FAIL rmid_outputs got=%h exp=0", {grant, done, dstart, quo, rem, undef, d_dvd, d_dvs});
        end
        req = 0;
        @(negedge clk);
        rst_n = 1;
        exp_p = 0; last_q = 0; last_r = 0; last_u = 0;
        @(posedge clk); #1;
        req = 2'b11;
        wait_done(who, q, r, u, st, cyc, g);
        total++; if (who !== rr_win(exp_p, 2'b11)) begin bad++; $display("FAIL rmid_who got=%0d exp=0", who); end
        total++; if ({q, r} !== {4'd4, 4'd1}) begin bad++; $display("FAIL rmid_result got=%h exp=41", {q, r}); end
        exp_p = 1; last_q = q; last_r = r; last_u = u;
        @(posedge clk); #1;
        req = 0;
    endtask

    task automatic test_operand_change();
        int who, st, cyc, seen;
        logic [3:0] q, r;
        logic u;
        logic [1:0] g;
        div_lat = 2;
        seen = 0;
        @(posedge clk); #1;
        dvd = {4'd0, 4'd15}; dvs = {4'd0, 4'd3}; req = 2'b01;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (dstart) seen = 1;
        end
        @(negedge clk);
        dvd = {4'd0, 4'd1}; dvs = {4'd0, 4'd1};
        #1;
        total++; if (d_dvd !== 4'd15) begin bad++; $display("FAIL opchg_latched got=%0d exp=15", d_dvd); end
        wait_done(who, q, r, u, st, cyc, g);
        total++; if ({q, r} !== {4'd5, 4'd0}) begin bad++; $display("FAIL opchg_result got=%h exp=50", {q, r}); end
        exp_p = 1; last_q = q; last_r = r; last_u = u;
        @(posedge clk); #1;
        req = 0;
    endtask

    task automatic test_random();
        int who, st, cyc, w;
        logic [3:0] q, r, a, b, eq, er;
        logic u, eu;
        logic [1:0] g, m;
        div_lat = -1;
        for (int n = 0; n < 24; n++) begin
            @(posedge clk); #1;
            m = 2'($urandom_range(3, 1));
            dvd = 8'($urandom);
            dvs = 8'($urandom);
            req = m;
            w = rr_win(exp_p, m);
            a = dvd[w*4 +: 4];
            b = dvs[w*4 +: 4];
            eq = (b == 0) ? 4'hF : a / b;
            er = (b == 0) ? a : a % b;
            eu = (b == 0);
            wait_done(who, q, r, u, st, cyc, g);
            total++;
            if (who !== w || {q, r, u} !== {eq, er, eu}) begin
                bad++;
                $display("FAIL rand[%0d] got=%0d/%h exp=%0d/%h", n, who, {q, r, u}, w, {eq, er, eu});
            end
            exp_p = (w + 1) % 2;
            @(posedge clk); #1;
            req = 0;
        end
    endtask

    initial begin
        rst_n = 0; req = 0; dvd = 0; dvs = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_divzero();
        test_cancel();
        test_reset_mid();
        test_operand_change();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
